// File: rtl/qam16_frame_ctrl_if.sv
// Byte-in / dibit-out bundle for the QAM16 frame sequencer.
// master = byte source and frame requester, slave = the sequencer itself.
interface qam16_frame_ctrl_if #(
  parameter int FCNT_W = 16
);
  logic              start;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [1:0]        dibit;
  logic              dibit_valid;
  logic              busy;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;
  logic              underflow;

  modport master (
    output start, s_data, s_valid,
    input  s_ready, dibit, dibit_valid, busy, frame_done, frame_cnt, underflow
  );

  modport slave (
    input  start, s_data, s_valid,
    output s_ready, dibit, dibit_valid, busy, frame_done, frame_cnt, underflow
  );
endinterface

// File: rtl/qam16_frame_ctrl.sv
// Frame sequencer: preamble then MSB-first payload dibits, one slot per DIV clocks; QAM16_CTRL_PAD_EN pads missing bytes with 8'h00.
// First dibit DIV cycles after start is taken; s_ready only in LOAD or a final slot, stalls in LOAD unless padding is enabled.
module qam16_frame_ctrl #(
  parameter int FRAME_BYTES = 64,
  parameter int PRE_DIBITS  = 8,
  parameter int DIV         = 4,
  parameter int FCNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  qam16_frame_ctrl_if.slave bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(PRE_DIBITS);
  localparam int BW = $clog2(FRAME_BYTES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_DIBITS - 1);
  localparam logic [BW-1:0] BYTES_ALL = BW'(FRAME_BYTES);

  typedef enum logic [2:0] {IDLE, PREAMBLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, nxt_state;
  logic [TW-1:0]     tick, nxt_tick;
  logic [PW-1:0]     pcnt, nxt_pcnt;
  logic [1:0]        sidx, nxt_sidx;
  logic [BW-1:0]     bcnt, nxt_bcnt;
  logic [7:0]        sh, nxt_sh;
  logic [1:0]        dibit_r;
  logic              dibit_valid_r;
  logic              frame_done_r;
  logic [FCNT_W-1:0] frame_cnt_r;
  logic              slot, last_pre, last_sub, more, s_ready_c, take;
  logic              nxt_slot;
  logic [1:0]        nxt_dibit;
`ifdef QAM16_CTRL_PAD_EN
  logic              underflow_r, nxt_uf;
`endif

  assign slot      = (tick == TICK_LAST);
  assign last_pre  = (state == PREAMBLE) && slot && (pcnt == PRE_LAST);
  assign last_sub  = (state == SHIFT) && slot && (sidx == 2'd3);
  assign more      = (bcnt != BYTES_ALL);
  assign s_ready_c = last_pre || (last_sub && more) || (state == LOAD);

  always_comb begin
    nxt_state = state;
    nxt_tick  = tick;
    nxt_pcnt  = pcnt;
    nxt_sidx  = sidx;
    nxt_bcnt  = bcnt;
    nxt_sh    = sh;
    take      = 1'b0;
`ifdef QAM16_CTRL_PAD_EN
    nxt_uf    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_state = PREAMBLE;
          nxt_tick  = '0;
          nxt_pcnt  = '0;
          nxt_sidx  = '0;
          nxt_bcnt  = '0;
        end
      end
      PREAMBLE: begin
        if (!slot) begin
          nxt_tick = tick + TW'(1);
        end else if (!last_pre) begin
          nxt_tick = '0;
          nxt_pcnt = pcnt + PW'(1);
        end
      end
      SHIFT: begin
        if (!slot) begin
          nxt_tick = tick + TW'(1);
        end else if (sidx != 2'd3) begin
          nxt_tick = '0;
          nxt_sidx = sidx + 2'd1;
        end else if (!more) begin
          nxt_state = DONE;
        end
      end
      DONE:    nxt_state = IDLE;
      default: ;
    endcase

    // Byte hand-off point: a starved request either pads or parks in LOAD.
    if (s_ready_c) begin
`ifdef QAM16_CTRL_PAD_EN
      take   = 1'b1;
      nxt_uf = !bus.s_valid;
`else
      take = bus.s_valid;
      if (!bus.s_valid) nxt_state = LOAD;
`endif
    end
    if (take) begin
      nxt_state = SHIFT;
      nxt_tick  = '0;
      nxt_sidx  = '0;
      nxt_bcnt  = bcnt + BW'(1);
      nxt_sh    = bus.s_valid ? bus.s_data : 8'h00;
    end

    // Outputs are registered, so the slot decision looks one cycle ahead.
    nxt_slot = ((nxt_state == PREAMBLE) || (nxt_state == SHIFT)) && (nxt_tick == TICK_LAST);
    if (nxt_state == PREAMBLE) begin
      nxt_dibit = nxt_pcnt[0] ? 2'b01 : 2'b10;
    end else begin
      case (nxt_sidx)
        2'd0:    nxt_dibit = nxt_sh[7:6];
        2'd1:    nxt_dibit = nxt_sh[5:4];
        2'd2:    nxt_dibit = nxt_sh[3:2];
        default: nxt_dibit = nxt_sh[1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick          <= '0;
      pcnt          <= '0;
      sidx          <= '0;
      bcnt          <= '0;
      sh            <= '0;
      dibit_r       <= '0;
      dibit_valid_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_cnt_r   <= '0;
`ifdef QAM16_CTRL_PAD_EN
      underflow_r   <= 1'b0;
`endif
    end else begin
      state         <= nxt_state;
      tick          <= nxt_tick;
      pcnt          <= nxt_pcnt;
      sidx          <= nxt_sidx;
      bcnt          <= nxt_bcnt;
      sh            <= nxt_sh;
      dibit_valid_r <= nxt_slot;
      if (nxt_slot) dibit_r <= nxt_dibit;
      frame_done_r  <= (nxt_state == DONE);
      if (nxt_state == DONE) frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
`ifdef QAM16_CTRL_PAD_EN
      underflow_r   <= nxt_uf;
`endif
    end
  end

  assign bus.s_ready     = s_ready_c;
  assign bus.dibit       = dibit_r;
  assign bus.dibit_valid = dibit_valid_r;
  assign bus.busy        = (state != IDLE);
  assign bus.frame_done  = frame_done_r;
  assign bus.frame_cnt   = frame_cnt_r;
`ifdef QAM16_CTRL_PAD_EN
  assign bus.underflow   = underflow_r;
`else
  assign bus.underflow   = 1'b0;
`endif

endmodule

// File: doc/qam16_frame_ctrl.md
Name: qam16_frame_ctrl

Overview:
Frame sequencer in front of the QAM16 mapper's 2-bit input buffer. It takes bytes from an upstream valid/ready source and, on `start`, emits one frame as a paced stream of dibits with a single-cycle `dibit_valid` strobe:
- a fixed preamble first,
- then FRAME_BYTES payload bytes, each serialised MSB-first.

Frames always carry an even number of dibits, so nibble pairing downstream stays aligned.

Parameters:
FRAME_BYTES, 64, payload bytes per frame (>=1)
PRE_DIBITS, 8, preamble length in dibits (even, >=2)
DIV, 4, clocks per dibit slot (>=1; 1 = one dibit per clock)
FCNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  request a frame; sampled only in IDLE
s_data  in  8  upstream byte
s_valid  in  1  upstream byte valid
s_ready  out  1  byte accepted when s_valid&&s_ready at posedge
dibit  out  2  dibit to mapper buffer (feeds its din)
dibit_valid  out  1  one-cycle strobe per dibit (feeds its din_valid)
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame
frame_cnt  out  FCNT_W  completed frames, wraps to 0
underflow  out  1  see Optional Feature; tied 0 when feature is out

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, dibit=0, dibit_valid=0, busy=0, frame_done=0, frame_cnt=0, underflow=0, all internal counters and the byte register cleared.
- States: IDLE, PREAMBLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 moves to PREAMBLE on the next edge.
  - start while busy is ignored (not queued).
- Pacing:
  - tick counter 0..DIV-1, cleared on entry to PREAMBLE and on entry to SHIFT from LOAD.
  - A slot fires on the cycle tick==DIV-1; dibit and dibit_valid are registered and valid on that slot cycle.
  - With DIV=1 every cycle is a slot.
  - dibit holds its last value when dibit_valid=0.
- PREAMBLE:
  - emits PRE_DIBITS dibits alternating 2'b10, 2'b01, starting with 2'b10.
  - s_ready=1 combinationally in the last preamble slot; a handshake there goes straight to SHIFT gaplessly. Otherwise go to LOAD.
- LOAD:
  - s_ready=1; tick is held.
  - On handshake, latch s_data and go to SHIFT; the first dibit appears DIV cycles later.
  - Stays in LOAD indefinitely while s_valid=0 (stall).
- SHIFT:
  - emits byte[7:6], [5:4], [3:2], [1:0] in four slots.
  - In the 4th slot, if bytes remain: s_ready=1; a handshake loads the next byte and stays in SHIFT (gapless), otherwise go to LOAD.
  - After the 4th slot of byte FRAME_BYTES: s_ready=0, go to DONE.
- DONE: one cycle with frame_done=1, frame_cnt+1 (mod 2^FCNT_W), then IDLE.
- s_ready is 0 in IDLE and DONE, and in all non-final slots.
- Frame length: exactly PRE_DIBITS + 4*FRAME_BYTES dibit_valid strobes per frame.
- Reset mid-frame: abort immediately, drop the held byte, return to IDLE. The mapper buffer must be reset on the same rst to keep pairing.

Optional Feature:
- Macro: QAM16_CTRL_PAD_EN.
- Defined:
  - When a byte is required and s_valid=0 (LOAD, or a final slot without handshake), substitute 8'h00 and continue without stalling.
  - Pacing stays uniform.
  - underflow pulses 1 cycle per padded byte.
  - LOAD is never occupied more than 1 cycle.
- Undefined: stall behaviour as above; underflow tied 0.

Test Plan:
- DIV=1, PRE_DIBITS=4, FRAME_BYTES=2, s_valid=1 with 0xB4 then 0x1E, start pulse cycle 0:
  - dibits on cycles 1..12 = 10,01,10,01,10,11,01,00,00,01,11,10, dibit_valid continuous;
  - frame_done=1 cycle 13, frame_cnt=1, busy 0 from cycle 14.
- DIV=4, same data: dibit_valid exactly every 4th cycle, 12 strobes total, no gap at the preamble/payload or byte/byte boundaries.
- s_valid=0 for 10 cycles before the second byte (PAD off): dibit_valid stops after the 4th payload dibit, resumes DIV cycles after the handshake, total strobes still 12.
- Same stall with QAM16_CTRL_PAD_EN: second byte emitted as 00,00,00,00, underflow one pulse, no stall, s_data byte not consumed.
- start asserted while busy, and rst asserted in mid-SHIFT:
  - start ignored;
  - after rst all outputs at reset values asynchronously, and the next start produces a full correct frame.
- FCNT_W=2, 5 frames: frame_cnt 1,2,3,0,1.
